// File: rtl/xbar_requester.sv
// Crossbar requester: buffers upstream flits in a small FIFO, presents the head
// flit to one crossbar port and reports grants, drops and starvation.
module xbar_requester #(
  parameter int PORTS      = 2,
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 4,
  parameter int STARVE_LIM = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic [PORTS-1:0] in_dest,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] xb_data,
  output logic [PORTS-1:0] xb_dest,
  output logic             xb_dest_en,
  input  logic             xb_ack,
  output logic             starve,
  output logic             drop,
  output logic [15:0]      sent_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = $clog2(STARVE_LIM + 1);
  localparam logic [CW-1:0]    FULL_V  = CW'(DEPTH);
  localparam logic [PORTS:0]   PORTS_V = (PORTS + 1)'(PORTS);
  localparam logic [WW-1:0]    LIM_V   = WW'(STARVE_LIM);

  typedef enum logic [1:0] {IDLE, REQ, STARVED} state_t;

  state_t           state;
  logic [WIDTH-1:0] mem_data [DEPTH];
  logic [PORTS-1:0] mem_dest [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_nxt;
  logic [WW-1:0]    wait_cnt;
  logic [WW-1:0]    wait_inc;
  logic             accept;
  logic             legal;
  logic             push;
  logic             grant;

  assign in_ready   = (count != FULL_V);
  assign accept     = in_valid && in_ready;
  assign legal      = ({1'b0, in_dest} < PORTS_V);
  assign push       = accept && legal;
  assign xb_dest_en = (count != '0);
  assign grant      = xb_dest_en && xb_ack;
  assign xb_data    = xb_dest_en ? mem_data[rd_ptr] : '0;
  assign xb_dest    = xb_dest_en ? mem_dest[rd_ptr] : '0;
  assign starve     = (state == STARVED);
  assign wait_inc   = (wait_cnt == LIM_V) ? wait_cnt : wait_cnt + WW'(1);

  always_comb begin
    count_nxt = count;
    case ({push, grant})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  // Payload storage carries no reset; validity is defined by the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= in_data;
      mem_dest[wr_ptr] <= in_dest;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      drop     <= 1'b0;
      sent_cnt <= '0;
    end else begin
      count <= count_nxt;
      drop  <= accept && !legal;
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (grant) begin
        rd_ptr   <= rd_ptr + AW'(1);
        sent_cnt <= sent_cnt + 16'd1;
      end
    end
  end

  // Request FSM: state REQ/STARVED exactly when the FIFO holds a flit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          wait_cnt <= '0;
          if (push)
            state <= REQ;
        end
        REQ, STARVED: begin
          if (grant) begin
            wait_cnt <= '0;
            state    <= (count_nxt == '0) ? IDLE : REQ;
          end else begin
            wait_cnt <= wait_inc;
            if (wait_inc == LIM_V)
              state <= STARVED;
          end
        end
        default: begin
          state    <= IDLE;
          wait_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xbar_requester.sv
// Bench for xbar_requester: directed and random traffic against a queue-based
// reference model, with a negedge monitor scoring every cycle.
module tb_xbar_requester;

  localparam int PORTS = 2;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int LIM   = 16;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic [PORTS-1:0] dest;
  } flit_t;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] in_data;
  logic [PORTS-1:0] in_dest;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] xb_data;
  logic [PORTS-1:0] xb_dest;
  logic             xb_dest_en;
  logic             xb_ack;
  logic             starve;
  logic             drop;
  logic [15:0]      sent_cnt;

  int checks   = 0;
  int failures = 0;

  flit_t       exp_q[$];
  int          m_occ     = 0;
  int          m_unacked = 0;
  logic        m_drop    = 1'b0;
  logic [15:0] m_sent    = '0;
  logic        mon_en    = 1'b0;

  xbar_requester #(
    .PORTS(PORTS), .WIDTH(WIDTH), .DEPTH(DEPTH), .STARVE_LIM(LIM)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_dest(in_dest), .in_valid(in_valid), .in_ready(in_ready),
    .xb_data(xb_data), .xb_dest(xb_dest), .xb_dest_en(xb_dest_en), .xb_ack(xb_ack),
    .starve(starve), .drop(drop), .sent_cnt(sent_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: advance by one clock edge using the inputs just applied.
  task automatic model_edge();
    bit acc, lgl, gnt;
    acc    = in_valid && (m_occ < DEPTH);
    lgl    = (int'(in_dest) < PORTS);
    gnt    = xb_ack && (m_occ > 0);
    m_drop = acc && !lgl;
    if (acc && lgl)
      exp_q.push_back('{data: in_data, dest: in_dest});
    if (gnt)
      m_sent = m_sent + 16'd1;
    if (gnt || m_occ == 0)
      m_unacked = 0;
    else if (m_unacked < LIM)
      m_unacked = m_unacked + 1;
    m_occ = m_occ + ((acc && lgl) ? 1 : 0) - (gnt ? 1 : 0);
  endtask

  task automatic step(input bit v, input logic [WIDTH-1:0] d, input logic [PORTS-1:0] de, input bit a);
    in_valid = v;
    in_data  = d;
    in_dest  = de;
    xb_ack   = a;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    mon_en   = 1'b0;
    in_valid = 1'b0;
    xb_ack   = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("rst_dest_en", 32'(xb_dest_en), 32'd0);
    chk("rst_data", 32'(xb_data), 32'd0);
    chk("rst_dest", 32'(xb_dest), 32'd0);
    chk("rst_sent_cnt", 32'(sent_cnt), 32'd0);
    chk("rst_drop", 32'(drop), 32'd0);
    chk("rst_starve", 32'(starve), 32'd0);
    exp_q.delete();
    m_occ     = 0;
    m_unacked = 0;
    m_drop    = 1'b0;
    m_sent    = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    mon_en = 1'b1;
  endtask

  // Scoreboard monitor: sampled mid-cycle while inputs and outputs are stable.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("in_ready", 32'(in_ready), 32'(m_occ != DEPTH));
      chk("xb_dest_en", 32'(xb_dest_en), 32'(m_occ != 0));
      chk("drop", 32'(drop), 32'(m_drop));
      chk("starve", 32'(starve), 32'(m_unacked >= LIM));
      chk("sent_cnt", 32'(sent_cnt), 32'(m_sent));
      if (xb_dest_en) begin
        if (xb_ack) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL grant_no_flit: got grant of %0h expected none at %0t", xb_data, $time);
          end else begin
            flit_t e;
            e = exp_q.pop_front();
            chk("grant_data", 32'(xb_data), 32'(e.data));
            chk("grant_dest", 32'(xb_dest), 32'(e.dest));
          end
        end
      end else begin
        chk("idle_data", 32'(xb_data), 32'd0);
        chk("idle_dest", 32'(xb_dest), 32'd0);
      end
    end
  end

  initial begin
    in_valid = 1'b0;
    in_data  = '0;
    in_dest  = '0;
    xb_ack   = 1'b0;
    do_reset();

    // Single flit with ack tied high.
    step(1, 8'hA5, 1, 1);
    step(0, 8'h00, 0, 1);
    step(0, 8'h00, 0, 1);

    // Fill to full, extra flit refused, then drain in order.
    for (int i = 0; i < DEPTH + 1; i++)
      step(1, 8'h10 + 8'(i), PORTS'(i % PORTS), 0);
    for (int i = 0; i < DEPTH + 1; i++)
      step(0, 8'h00, 0, 1);

    // Starvation and recovery with a single ack pulse.
    step(1, 8'h3C, 0, 0);
    for (int i = 0; i < LIM + 4; i++)
      step(0, 8'h00, 0, 0);
    step(0, 8'h00, 0, 1);
    step(0, 8'h00, 0, 0);

    // Simultaneous push and grant at occupancy 2.
    step(1, 8'h21, 0, 0);
    step(1, 8'h22, 1, 0);
    step(1, 8'h23, 0, 1);
    step(1, 8'h24, 1, 1);
    for (int i = 0; i < DEPTH; i++)
      step(0, 8'h00, 0, 1);

    // Illegal destinations are dropped.
    step(1, 8'h77, 2, 0);
    step(1, 8'h78, 3, 0);
    step(0, 8'h00, 0, 0);
    step(0, 8'h00, 0, 0);

    // Randomised traffic.
    for (int i = 0; i < 600; i++) begin
      logic [PORTS-1:0] d;
      d = ($urandom_range(0, 7) == 0) ? PORTS'($urandom_range(2, 3)) : PORTS'($urandom_range(0, 1));
      step($urandom_range(0, 9) < 7, 8'($urandom), d, ($urandom_range(0, 9) < 4));
    end
    for (int i = 0; i < DEPTH + 2; i++)
      step(0, 8'h00, 0, 1);

    // Mid-operation reset with three flits queued.
    for (int i = 0; i < 3; i++)
      step(1, 8'hC0 + 8'(i), PORTS'(i % PORTS), 0);
    do_reset();
    for (int i = 0; i < 4; i++)
      step(0, 8'h00, 0, 1);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
